// File: rtl/reduce_stream_pkg.sv
// Shared types and defaults for the reduce_stream stage (token layout, default sizes).
// The token fields are sized by REDUCE_WIDTH_DEFAULT; the top's WIDTH must match it.
package reduce_stream_pkg;

  localparam int REDUCE_N_ARR_DEFAULT = 3;
  localparam int REDUCE_WIDTH_DEFAULT = 4;

  typedef struct packed {
    logic [REDUCE_WIDTH_DEFAULT-1:0] data;
    logic [REDUCE_WIDTH_DEFAULT-1:0] operand;
    logic                            orr;
    logic                            andr;
  } token_t;

  function automatic token_t make_token(
    input logic [REDUCE_WIDTH_DEFAULT-1:0] operand,
    input logic [REDUCE_WIDTH_DEFAULT-1:0] data
  );
    token_t t;
    t.data    = data;
    t.operand = operand;
    t.orr     = |operand;
    t.andr    = &operand;
    return t;
  endfunction

  // Combined flag, recomputed from the stored operand so it cannot drift from orr/andr.
  function automatic logic token_out(input token_t t);
    return (|t.operand) && (&t.operand);
  endfunction

endpackage

// File: rtl/reduce_stream_fork.sv
// Done-mask fork: offers the head token to N consumers and retires it once all have taken it.
// Handshake: a consumer transfers when valid && ready at a rising edge; valid holds until then.
module reduce_stream_fork
  import reduce_stream_pkg::*;
#(
  parameter int N = REDUCE_N_ARR_DEFAULT + 1
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         head_v,
  input  logic [N-1:0] ready,
  output logic [N-1:0] valid,
  output logic         retire
);

  logic [N-1:0] done;
  logic [N-1:0] take;

  always_comb begin
    valid  = {N{head_v}} & ~done;
    take   = valid & ready;
    // Bits being set this cycle count, so all-ready retires on the first edge.
    retire = head_v && (&(done | take));
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      done <= '0;
    end else if (retire) begin
      done <= '0;
    end else begin
      done <= done | take;
    end
  end

endmodule

// File: rtl/reduce_stream_stage.sv
// Registered reduction stage: stores {in1, in2, |in1, &in1} tokens and forks each to N_ARR+1 consumers.
// REDUCE_STREAM_SKID_EN: 2-entry storage with registered in_ready; otherwise 1 entry with in_ready = !head_v || retire.
module reduce_stream_stage
  import reduce_stream_pkg::*;
#(
  parameter int WIDTH = REDUCE_WIDTH_DEFAULT,
  parameter int N_ARR = REDUCE_N_ARR_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out,
  output logic             orr_o,
  output logic             andr_o,
  output logic [WIDTH-1:0] data_o,
  output logic             handshake_valid,
  input  logic             handshake_ready,
  output logic [N_ARR-1:0] handshake_arr_valid,
  input  logic [N_ARR-1:0] handshake_arr_ready
);

  token_t     head;
  logic       head_v;
  logic       retire;
  logic       in_fire;
  token_t     new_tok;
  logic [N_ARR:0] fork_valid;

  always_comb begin
    in_fire = in_valid && in_ready;
    new_tok = make_token(in1, in2);
  end

  // Primary consumer owns the top bit of the fork vector.
  reduce_stream_fork #(.N(N_ARR + 1)) u_fork (
    .CLK    (CLK),
    .RESETN (RESETN),
    .head_v (head_v),
    .ready  ({handshake_ready, handshake_arr_ready}),
    .valid  (fork_valid),
    .retire (retire)
  );

  assign handshake_valid     = fork_valid[N_ARR];
  assign handshake_arr_valid = fork_valid[N_ARR-1:0];

`ifdef REDUCE_STREAM_SKID_EN
  token_t     slot1;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       in_ready_q;

  assign in_ready = in_ready_q;

  always_comb begin
    count_next = count + 2'(in_fire) - 2'(retire);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      head       <= '0;
      slot1      <= '0;
      head_v     <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      count      <= count_next;
      head_v     <= (count_next != 2'd0);
      in_ready_q <= (count_next != 2'd2);
      if (retire) begin
        // Full storage never accepts, so retire-while-full only promotes slot1.
        if (count == 2'd2) begin
          head <= slot1;
        end else if (in_fire) begin
          head <= new_tok;
        end
      end else if (in_fire) begin
        if (!head_v) begin
          head <= new_tok;
        end else begin
          slot1 <= new_tok;
        end
      end
    end
  end
`else
  assign in_ready = !head_v || retire;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      head   <= '0;
      head_v <= 1'b0;
    end else begin
      if (in_fire) begin
        head <= new_tok;
      end
      head_v <= in_fire || (head_v && !retire);
    end
  end
`endif

  assign out    = token_out(head);
  assign orr_o  = head.orr;
  assign andr_o = head.andr;
  assign data_o = head.data;

endmodule

// File: tb/tb_reduce_stream_stage.sv
// Directed bench for reduce_stream_stage: per-consumer expected queues filled on input accept,
// popped by a negedge monitor on each consumer transfer.
module tb_reduce_stream_stage;

  localparam int WIDTH = 4;
  localparam int N_ARR = 3;
`ifdef REDUCE_STREAM_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  logic             CLK;
  logic             RESETN;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out;
  logic             orr_o;
  logic             andr_o;
  logic [WIDTH-1:0] data_o;
  logic             handshake_valid;
  logic             handshake_ready;
  logic [N_ARR-1:0] handshake_arr_valid;
  logic [N_ARR-1:0] handshake_arr_ready;

  reduce_stream_stage #(.WIDTH(WIDTH), .N_ARR(N_ARR)) dut (
    .CLK                 (CLK),
    .RESETN              (RESETN),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in1                 (in1),
    .in2                 (in2),
    .out                 (out),
    .orr_o               (orr_o),
    .andr_o              (andr_o),
    .data_o              (data_o),
    .handshake_valid     (handshake_valid),
    .handshake_ready     (handshake_ready),
    .handshake_arr_valid (handshake_arr_valid),
    .handshake_arr_ready (handshake_arr_ready)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard state: expected {out, orr, andr, data}
  logic [6:0] exp_q[$];
  logic [6:0] f0_q[$];
  logic [6:0] f1_q[$];
  logic [6:0] f2_q[$];
  logic [6:0] cur_exp;
  int checks = 0;
  int errors = 0;
  logic took;
  int acc;

  // Directed vectors: in1, in2, hand-computed {out, orr, andr, data}
  logic [3:0] v_in1 [12];
  logic [3:0] v_in2 [12];
  logic [6:0] v_exp [12];

  initial begin
    v_in1[0]  = 4'hF; v_in2[0]  = 4'h3; v_exp[0]  = {3'b111, 4'h3};
    v_in1[1]  = 4'h4; v_in2[1]  = 4'h5; v_exp[1]  = {3'b010, 4'h5};
    v_in1[2]  = 4'h0; v_in2[2]  = 4'h9; v_exp[2]  = {3'b000, 4'h9};
    v_in1[3]  = 4'hA; v_in2[3]  = 4'h6; v_exp[3]  = {3'b010, 4'h6};
    v_in1[4]  = 4'hB; v_in2[4]  = 4'h1; v_exp[4]  = {3'b010, 4'h1};
    v_in1[5]  = 4'h7; v_in2[5]  = 4'h2; v_exp[5]  = {3'b010, 4'h2};
    v_in1[6]  = 4'hF; v_in2[6]  = 4'hC; v_exp[6]  = {3'b111, 4'hC};
    v_in1[7]  = 4'h8; v_in2[7]  = 4'hD; v_exp[7]  = {3'b010, 4'hD};
    v_in1[8]  = 4'h1; v_in2[8]  = 4'hE; v_exp[8]  = {3'b010, 4'hE};
    v_in1[9]  = 4'h5; v_in2[9]  = 4'h0; v_exp[9]  = {3'b010, 4'h0};
    v_in1[10] = 4'hF; v_in2[10] = 4'hF; v_exp[10] = {3'b111, 4'hF};
    v_in1[11] = 4'hF; v_in2[11] = 4'hA; v_exp[11] = {3'b111, 4'hA};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic empty_pop(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=transfer required=no_token_pending", name);
  endtask

  // Driver tasks
  task automatic drive(input int idx);
    in_valid = 1'b1;
    in1      = v_in1[idx];
    in2      = v_in2[idx];
    cur_exp  = v_exp[idx];
  endtask

  task automatic at_neg();
    @(negedge CLK);
    took = in_valid && in_ready;
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
    if (took) in_valid = 1'b0;
  endtask

  task automatic set_ready(input logic p, input logic [N_ARR-1:0] f);
    handshake_ready     = p;
    handshake_arr_ready = f;
  endtask

  // Monitor: pops per consumer on transfer, pushes on input accept
  always @(negedge CLK) begin
    logic [6:0] obs;
    logic [6:0] e;
    obs = {out, orr_o, andr_o, data_o};
    if (RESETN) begin
      if (handshake_valid && handshake_ready) begin
        if (exp_q.size() == 0) empty_pop("primary_tok");
        else begin
          e = exp_q.pop_front();
          check("primary_tok", 32'(obs), 32'(e));
          check("primary_out_prop", 32'(out), 32'(orr_o && andr_o));
        end
      end
      if (handshake_arr_valid[0] && handshake_arr_ready[0]) begin
        if (f0_q.size() == 0) empty_pop("fork0_tok");
        else begin e = f0_q.pop_front(); check("fork0_tok", 32'(obs), 32'(e)); end
      end
      if (handshake_arr_valid[1] && handshake_arr_ready[1]) begin
        if (f1_q.size() == 0) empty_pop("fork1_tok");
        else begin e = f1_q.pop_front(); check("fork1_tok", 32'(obs), 32'(e)); end
      end
      if (handshake_arr_valid[2] && handshake_arr_ready[2]) begin
        if (f2_q.size() == 0) empty_pop("fork2_tok");
        else begin e = f2_q.pop_front(); check("fork2_tok", 32'(obs), 32'(e)); end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        f0_q.push_back(cur_exp);
        f1_q.push_back(cur_exp);
        f2_q.push_back(cur_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    RESETN   = 1'b0;
    in_valid = 1'b0;
    in1      = '0;
    in2      = '0;
    cur_exp  = '0;
    took     = 1'b0;
    set_ready(1'b0, 3'b000);
    repeat (2) @(posedge CLK);
    #1;
    RESETN = 1'b1;

    // Reset state
    at_neg();
    check("rst_hs_valid", 32'(handshake_valid), 0);
    check("rst_arr_valid", 32'(handshake_arr_valid), 0);
    check("rst_out", 32'(out), 0);
    check("rst_orr", 32'(orr_o), 0);
    check("rst_andr", 32'(andr_o), 0);
    check("rst_data", 32'(data_o), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    next();

    // Full throughput with all consumers ready
    set_ready(1'b1, 3'b111);
    for (int i = 0; i < 4; i++) begin
      drive(i);
      at_neg();
      check("tput_in_ready", 32'(in_ready), 1);
      if (i > 0) check("lat_valids", 32'({handshake_valid, handshake_arr_valid}), 32'hF);
      next();
    end
    at_neg();
    check("lat_valids_last", 32'({handshake_valid, handshake_arr_valid}), 32'hF);
    next();
    at_neg();
    check("drained_valids", 32'({handshake_valid, handshake_arr_valid}), 0);
    next();

    // Staggered readies
    set_ready(1'b0, 3'b000);
    drive(4);
    at_neg();
    next();
    drive(5);
    set_ready(1'b0, 3'b001);
    at_neg();
    check("stag_c1", 32'({handshake_valid, handshake_arr_valid}), 32'hF);
    next();
    set_ready(1'b1, 3'b001);
    at_neg();
    check("stag_c2", 32'({handshake_valid, handshake_arr_valid}), 32'hE);
    next();
    at_neg();
    check("stag_c3", 32'({handshake_valid, handshake_arr_valid}), 32'h6);
    next();
    set_ready(1'b1, 3'b111);
    at_neg();
    check("stag_c4", 32'({handshake_valid, handshake_arr_valid}), 32'h6);
    next();
    at_neg();
    check("stag_c5_next", 32'({handshake_valid, handshake_arr_valid}), 32'hF);
    next();

    // Backpressure: feed 3 words with every consumer stalled
    set_ready(1'b0, 3'b000);
    acc = 0;
    drive(6);
    for (int c = 0; c < 6; c++) begin
      at_neg();
      if (took) acc++;
      next();
      if (took && acc < 3) drive(6 + acc);
    end
    check("bp_accepted", 32'(acc), 32'(EXP_ACC));
    check("bp_in_ready", 32'(in_ready), 0);
    set_ready(1'b1, 3'b111);
    for (int c = 0; c < 20 && acc < 3; c++) begin
      at_neg();
      if (took) acc++;
      next();
      if (took && acc < 3) drive(6 + acc);
    end
    check("bp_drain_all", 32'(acc), 3);
    repeat (4) begin
      at_neg();
      next();
    end

    // Reset with a partially taken head and a second token waiting
    set_ready(1'b0, 3'b000);
    drive(9);
    at_neg();
    next();
    drive(10);
    set_ready(1'b0, 3'b010);
    at_neg();
    next();
    set_ready(1'b0, 3'b000);
    in_valid = 1'b0;
    RESETN   = 1'b0;
    at_neg();
    next();
    exp_q.delete();
    f0_q.delete();
    f1_q.delete();
    f2_q.delete();
    RESETN = 1'b1;
    at_neg();
    check("rstmid_valids", 32'({handshake_valid, handshake_arr_valid}), 0);
    check("rstmid_in_ready", 32'(in_ready), 1);
    next();
    set_ready(1'b1, 3'b111);
    drive(11);
    at_neg();
    next();
    at_neg();
    check("rstmid_first_tok", 32'({handshake_valid, handshake_arr_valid}), 32'hF);
    next();
    repeat (3) begin
      at_neg();
      next();
    end

    check("q_empty_primary", 32'(exp_q.size()), 0);
    check("q_empty_fork0", 32'(f0_q.size()), 0);
    check("q_empty_fork1", 32'(f1_q.size()), 0);
    check("q_empty_fork2", 32'(f2_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
